// File: rtl/memory_fifo.sv
// Cascaded pixel line-buffer: N equal-depth circular FIFOs chained into one delay line.
// Each stage exposes its oldest entry as a tap spaced one stage-depth from its neighbour.
module memory_fifo #(
    parameter int ADDR_WIDTH           = 4,
    parameter int DATA_WIDTH           = 8,
    parameter int FIFO_COMPONENT_COUNT = 6
) (
    input  logic                                       clk,
    input  logic                                       reset_os,
    input  logic [DATA_WIDTH-1:0]                      pixel,
    input  logic                                       wen,
    output logic [FIFO_COMPONENT_COUNT*DATA_WIDTH-1:0] o_tap,
    output logic [FIFO_COMPONENT_COUNT-1:0]            o_valid,
    output logic                                       o_all_ready
);

    localparam int N     = FIFO_COMPONENT_COUNT;
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] CNT_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};

    // Write handshake: wen has no ready; every edge with wen=1 accepts pixel.
    // Stage k+1 is written exactly when stage k is written while already full.
    logic [N-1:0]                 wr;
    logic [N-1:0]                 full;
    logic [N-1:0]                 not_empty;
    logic [N-1:0][DATA_WIDTH-1:0] head;

    genvar k;
    generate
        for (k = 0; k < N; k++) begin : g_stage
            logic [DATA_WIDTH-1:0] mem [DEPTH];
            logic [ADDR_WIDTH-1:0] rd_ptr;
            logic [ADDR_WIDTH-1:0] wr_ptr;
            logic [ADDR_WIDTH:0]   count;
            logic [DATA_WIDTH-1:0] din;

            if (k == 0) begin : g_first
                assign wr[k] = wen;
                assign din   = pixel;
            end else begin : g_chain
                assign wr[k] = wr[k-1] & full[k-1];
                assign din   = head[k-1];
            end

            assign full[k]      = (count == CNT_FULL);
            assign not_empty[k] = (count != '0);
            assign head[k]      = mem[rd_ptr];

            always_ff @(posedge clk or negedge reset_os) begin
                if (!reset_os) begin
                    rd_ptr <= '0;
                    wr_ptr <= '0;
                    count  <= '0;
                end else if (wr[k]) begin
                    wr_ptr <= wr_ptr + 1'b1;
                    // When full, rd_ptr == wr_ptr: the head leaves as the new sample lands.
                    if (full[k]) begin
                        rd_ptr <= rd_ptr + 1'b1;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
            end

            // Storage needs no reset; taps are masked while the stage is empty.
            always_ff @(posedge clk) begin
                if (wr[k]) begin
                    mem[wr_ptr] <= din;
                end
            end

            assign o_tap[k*DATA_WIDTH +: DATA_WIDTH] = not_empty[k] ? head[k] : '0;
        end
    endgenerate

    assign o_valid     = full;
    assign o_all_ready = &full;

endmodule

// File: tb/tb_memory_fifo.sv
// Self-checking bench for memory_fifo: directed delay-line scenarios plus a randomized
// stream compared against a history-based closed-form model of the taps.
module tb_memory_fifo;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int N  = 6;
    localparam int D  = 1 << AW;

    logic              clk;
    logic              reset_os;
    logic [DW-1:0]     pixel;
    logic              wen;
    logic [N*DW-1:0]   o_tap;
    logic [N-1:0]      o_valid;
    logic              o_all_ready;

    int checks = 0;
    int errors = 0;

    // Model: every accepted sample since reset, in write order.
    logic [DW-1:0] exp_q[$];
    int            m = 0;

    memory_fifo #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .FIFO_COMPONENT_COUNT(N)
    ) dut (
        .clk(clk),
        .reset_os(reset_os),
        .pixel(pixel),
        .wen(wen),
        .o_tap(o_tap),
        .o_valid(o_valid),
        .o_all_ready(o_all_ready)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Reference: stage k holds min(D, max(0, m-k*D)) entries; its head is sample
    // #(m-(k+1)*D) once full, otherwise the very first sample of the stream.
    function automatic logic [DW-1:0] model_tap(input int k);
        int cnt;
        int idx;
        cnt = m - k * D;
        if (cnt <= 0) return '0;
        idx = m - (k + 1) * D;
        if (idx < 0) idx = 0;
        return exp_q[idx];
    endfunction

    function automatic logic [N-1:0] model_valid();
        logic [N-1:0] v;
        for (int k = 0; k < N; k++) v[k] = (m >= (k + 1) * D);
        return v;
    endfunction

    function automatic logic [DW-1:0] tap(input int k);
        return o_tap[k*DW +: DW];
    endfunction

    // Driver tasks
    task automatic drive(input logic w, input logic [DW-1:0] p);
        wen   = w;
        pixel = p;
        @(posedge clk);
        #1;
        if (w) begin
            exp_q.push_back(p);
            m++;
        end
        wen = 1'b0;
    endtask

    task automatic fill_to(input int target);
        while (m < target) drive(1'b1, DW'(m));
    endtask

    task automatic apply_reset();
        reset_os = 1'b0;
        #3;
        exp_q.delete();
        m = 0;
        reset_os = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        wen      = 1'b0;
        pixel    = '0;
        reset_os = 1'b0;
        #12;
        checks++;
        if (o_tap !== '0) begin
            errors++;
            $display("FAIL reset_tap: got %h expected 0", o_tap);
        end
        checks++;
        if (o_valid !== '0) begin
            errors++;
            $display("FAIL reset_valid: got %b expected 0", o_valid);
        end
        checks++;
        if (o_all_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_all_ready: got %b expected 0", o_all_ready);
        end
        reset_os = 1'b1;
        exp_q.delete();
        m = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_fill();
        fill_to(15);
        checks++;
        if (o_valid !== 6'b000000 || tap(0) !== 8'd0) begin
            errors++;
            $display("FAIL fill15: valid=%b tap0=%0d expected valid=000000 tap0=0", o_valid, tap(0));
        end
        fill_to(16);
        checks++;
        if (o_valid !== 6'b000001 || tap(0) !== 8'd0) begin
            errors++;
            $display("FAIL fill16: valid=%b tap0=%0d expected valid=000001 tap0=0", o_valid, tap(0));
        end
        fill_to(17);
        checks++;
        if (tap(0) !== 8'd1 || tap(1) !== 8'd0 || o_valid[1] !== 1'b0) begin
            errors++;
            $display("FAIL fill17: tap0=%0d tap1=%0d valid1=%b expected 1 0 0", tap(0), tap(1), o_valid[1]);
        end
        fill_to(32);
        checks++;
        if (o_valid !== 6'b000011 || tap(0) !== 8'd16 || tap(1) !== 8'd0) begin
            errors++;
            $display("FAIL fill32: valid=%b tap0=%0d tap1=%0d expected 000011 16 0", o_valid, tap(0), tap(1));
        end
        fill_to(95);
        checks++;
        if (o_all_ready !== 1'b0 || o_valid !== 6'b011111) begin
            errors++;
            $display("FAIL fill95: all_ready=%b valid=%b expected 0 011111", o_all_ready, o_valid);
        end
        fill_to(96);
        checks++;
        if (o_all_ready !== 1'b1 || tap(5) !== 8'd0 || tap(0) !== 8'd80) begin
            errors++;
            $display("FAIL fill96: all_ready=%b tap5=%0d tap0=%0d expected 1 0 80", o_all_ready, tap(5), tap(0));
        end
        fill_to(97);
        checks++;
        if (tap(5) !== 8'd1 || tap(0) !== 8'd81) begin
            errors++;
            $display("FAIL fill97: tap5=%0d tap0=%0d expected 1 81", tap(5), tap(0));
        end
        for (int k = 0; k < N; k++) begin
            checks++;
            if (tap(k) !== model_tap(k)) begin
                errors++;
                $display("FAIL fill97_tap%0d: got %0d expected %0d", k, tap(k), model_tap(k));
            end
        end
    endtask

    task automatic test_hold();
        fill_to(120);
        for (int c = 0; c < 10; c++) begin
            drive(1'b0, DW'($urandom_range(0, 255)));
            checks++;
            if (o_valid !== model_valid() || o_all_ready !== 1'b1 ||
                tap(0) !== model_tap(0) || tap(3) !== model_tap(3) || tap(5) !== model_tap(5)) begin
                errors++;
                $display("FAIL hold_cycle%0d: valid=%b ready=%b tap0=%0d tap3=%0d tap5=%0d expected %b 1 %0d %0d %0d",
                         c, o_valid, o_all_ready, tap(0), tap(3), tap(5),
                         model_valid(), model_tap(0), model_tap(3), model_tap(5));
            end
        end
        fill_to(125);
        for (int k = 0; k < N; k++) begin
            checks++;
            if (tap(k) !== DW'(125 - (k + 1) * D)) begin
                errors++;
                $display("FAIL hold_resume_tap%0d: got %0d expected %0d", k, tap(k), 125 - (k + 1) * D);
            end
        end
    endtask

    task automatic test_wrap();
        fill_to(271);
        checks++;
        if (tap(0) !== 8'd255) begin
            errors++;
            $display("FAIL wrap271_tap0: got %0d expected 255", tap(0));
        end
        fill_to(272);
        checks++;
        if (tap(0) !== 8'd0) begin
            errors++;
            $display("FAIL wrap272_tap0: got %0d expected 0", tap(0));
        end
        fill_to(352);
        for (int k = 0; k < N; k++) begin
            checks++;
            if (tap(k) !== model_tap(k)) begin
                errors++;
                $display("FAIL wrap352_tap%0d: got %0d expected %0d", k, tap(k), model_tap(k));
            end
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        fill_to(40);
        #2;
        reset_os = 1'b0;
        #1;
        checks++;
        if (o_tap !== '0 || o_valid !== '0 || o_all_ready !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: tap=%h valid=%b ready=%b expected all 0", o_tap, o_valid, o_all_ready);
        end
        #2;
        exp_q.delete();
        m = 0;
        reset_os = 1'b1;
        @(posedge clk);
        #1;
        fill_to(15);
        checks++;
        if (o_valid[0] !== 1'b0 || tap(0) !== 8'd0) begin
            errors++;
            $display("FAIL refill15: valid0=%b tap0=%0d expected 0 0", o_valid[0], tap(0));
        end
        fill_to(16);
        checks++;
        if (o_valid[0] !== 1'b1 || o_valid[1] !== 1'b0) begin
            errors++;
            $display("FAIL refill16: valid=%b expected 000001", o_valid);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            drive(($urandom_range(0, 3) != 0), DW'($urandom_range(0, 255)));
            checks++;
            if (o_valid !== model_valid() || o_all_ready !== (&model_valid())) begin
                errors++;
                $display("FAIL rand_valid cycle%0d: valid=%b ready=%b expected %b", c, o_valid, o_all_ready, model_valid());
            end
            for (int k = 0; k < N; k++) begin
                checks++;
                if (tap(k) !== model_tap(k)) begin
                    errors++;
                    $display("FAIL rand_tap%0d cycle%0d: got %0d expected %0d", k, c, tap(k), model_tap(k));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_hold();
        test_wrap();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
